// File: rtl/zstr_pkg.sv
// Shared types and helpers for the z-stream source and its queue.
package zstr_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} zstr_src_state_t;

    // Width of a counter able to hold 0..ql inclusive.
    function automatic int cnt_w(input int ql);
        return $clog2(ql + 1);
    endfunction

endpackage

// File: rtl/zstr_fifo.sv
// Circular buffer with occupancy count and two read ports: head and the entry after it.
module zstr_fifo
    import zstr_pkg::*;
#(
    parameter int W  = 9,
    parameter int QL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         wdata,
    output logic [W-1:0]         head,
    output logic [W-1:0]         next,
    output logic [cnt_w(QL)-1:0] cnt
);

    localparam int PW = (QL > 1) ? $clog2(QL) : 1;
    localparam int CW = cnt_w(QL);

    logic [W-1:0]  mem [QL];
    logic [PW-1:0] wptr, rptr;

    // Pointers wrap at QL-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(QL - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rptr];
    assign next = mem[inc(rptr)];

endmodule

// File: rtl/zstr_src.sv
// Z-stream transmitter: replays queued {delay, payload} entries onto z_vld/z_bus
// with the programmed idle gap before each transfer.
module zstr_src
    import zstr_pkg::*;
#(
    parameter int   BW = 1,
    parameter logic XZ = 1'bx,
    parameter int   QL = 4,
    parameter int   DW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     put_vld,
    output logic                     put_rdy,
    input  logic [BW-1:0]            put_bus,
    input  logic [DW-1:0]            put_dly,
    output logic                     z_vld,
    output logic [BW-1:0]            z_bus,
    input  logic                     z_rdy,
    output logic [$clog2(QL+1)-1:0]  q_cnt,
    output logic [31:0]              trn_cnt
);

    localparam int W  = BW + DW;
    localparam int CW = cnt_w(QL);

    zstr_src_state_t state;
    logic [DW-1:0]   dcnt;
    logic [W-1:0]    head, next;
    logic            push, z_trn;

    logic [DW-1:0] head_dly, next_dly;
    logic [BW-1:0] head_bus, next_bus;

    assign head_dly = head[BW +: DW];
    assign head_bus = head[BW-1:0];
    assign next_dly = next[BW +: DW];
    assign next_bus = next[BW-1:0];

    assign put_rdy = (q_cnt < CW'(QL));
    assign push    = put_vld & put_rdy;
    assign z_trn   = z_vld & z_rdy;

    zstr_fifo #(.W(W), .QL(QL)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (z_trn),
        .wdata ({put_dly, put_bus}),
        .head  (head),
        .next  (next),
        .cnt   (q_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dcnt  <= '0;
            z_vld <= 1'b0;
            z_bus <= {BW{XZ}};
        end else begin
            case (state)
                IDLE: begin
                    if (q_cnt != '0) begin
                        if (head_dly == '0) begin
                            state <= SEND;
                            z_vld <= 1'b1;
                            z_bus <= head_bus;
                        end else begin
                            state <= WAIT;
                            dcnt  <= head_dly - 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (dcnt == '0) begin
                        state <= SEND;
                        z_vld <= 1'b1;
                        z_bus <= head_bus;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                SEND: begin
                    // Lookahead uses the pre-edge count, so a word pushed on the
                    // last pop edge is picked up from IDLE one cycle later.
                    if (z_trn) begin
                        if (q_cnt > CW'(1)) begin
                            if (next_dly == '0) begin
                                z_bus <= next_bus;
                            end else begin
                                state <= WAIT;
                                dcnt  <= next_dly - 1'b1;
                                z_vld <= 1'b0;
                                z_bus <= {BW{XZ}};
                            end
                        end else begin
                            state <= IDLE;
                            z_vld <= 1'b0;
                            z_bus <= {BW{XZ}};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    z_vld <= 1'b0;
                    z_bus <= {BW{XZ}};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     trn_cnt <= '0;
        else if (z_trn) trn_cnt <= trn_cnt + 32'd1;
    end

endmodule
